// File: rtl/decoder_bo_pkg.sv
// Shared Hamming(15,11) definitions used by the decoder and the matching encoder.
package decoder_bo_pkg;

  localparam int DATA_W = 11;
  localparam int CODE_W = 15;
  localparam int SYN_W  = 4;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [SYN_W-1:0]  syn_t;

  // Parity coverage: bit i of a mask is set when code position i+1 has that syndrome bit set.
  localparam code_t PAR_MASK0 = 15'h5555;
  localparam code_t PAR_MASK1 = 15'h6666;
  localparam code_t PAR_MASK2 = 15'h7878;
  localparam code_t PAR_MASK3 = 15'h7F80;

  // Stage-1 register contents: raw codeword plus its syndrome.
  typedef struct packed {
    logic  valid;
    code_t cw;
    syn_t  syn;
  } stage1_t;

  // Stage-2 register contents: what the consumer sees.
  typedef struct packed {
    logic  valid;
    data_t data;
    syn_t  syn;
    logic  err;
  } stage2_t;

  function automatic syn_t syndrome_of(input code_t cw);
    syn_t s;
    s[0] = ^(cw & PAR_MASK0);
    s[1] = ^(cw & PAR_MASK1);
    s[2] = ^(cw & PAR_MASK2);
    s[3] = ^(cw & PAR_MASK3);
    return s;
  endfunction

  // Data bits sit at every non-power-of-two code position.
  function automatic data_t extract_data(input code_t cw);
    return {cw[14:8], cw[6], cw[5], cw[4], cw[2]};
  endfunction

  // Encoder: place data, then the parity bits equal the syndrome of the zero-parity word.
  function automatic code_t encode(input data_t d);
    code_t cw;
    syn_t  s;
    cw = '0;
    cw[2]    = d[0];
    cw[4]    = d[1];
    cw[5]    = d[2];
    cw[6]    = d[3];
    cw[14:8] = d[10:4];
    s = syndrome_of(cw);
    cw[0] = s[0];
    cw[1] = s[1];
    cw[3] = s[2];
    cw[7] = s[3];
    return cw;
  endfunction

endpackage

// File: rtl/decoder_bo_correct.sv
// Single-error correction: flips the bit named by the syndrome and extracts the data field.
module hamming15_correct
  import decoder_bo_pkg::*;
(
  input  code_t cw,
  input  syn_t  syn,
  output data_t data,
  output logic  err
);

  code_t flip;
  code_t fixed;

  // Build a one-hot flip mask from the syndrome (none when the syndrome is zero).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    flip = '0;
    if (syn != '0) begin
      flip = code_t'(1) << (syn - syn_t'(1));
    end
    fixed = cw ^ flip;
    data  = extract_data(fixed);
    err   = (syn != '0);
  end

endmodule

// File: rtl/decoder_bo.sv
// Two-stage Hamming(15,11) decoder with valid/ready flow control and a saturating error counter.
module decoder_bo
  import decoder_bo_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [14:0]      data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [10:0]      data_out,
  output logic [3:0]       syndrome,
  output logic             err_corr,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  stage1_t          s1_q, s1_d;
  stage2_t          s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic  en;
  logic  inc;
  data_t corr_data;
  logic  corr_err;

  hamming15_correct u_correct (
    .cw   (s1_q.cw),
    .syn  (s1_q.syn),
    .data (corr_data),
    .err  (corr_err)
  );

  // Pipeline advance: both stages move together whenever the output slot is free or being taken.
  always_comb begin
    en   = !s2_q.valid || out_ready;
    s1_d = s1_q;
    s2_d = s2_q;
    if (en) begin
      s1_d.valid = in_valid;
      s1_d.cw    = data_in;
      s1_d.syn   = syndrome_of(data_in);
      s2_d.valid = s1_q.valid;
      s2_d.data  = corr_data;
      s2_d.syn   = s1_q.syn;
      s2_d.err   = corr_err;
    end
  end

  // Error counter: counts delivered corrected words, saturates, and a clear beats an increment.
  always_comb begin
    inc   = s2_q.valid && out_ready && s2_q.err;
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      // NOTE: data fields are reset along with the valid flags so the outputs read zero after reset.
      s1_q  <= '0;
      s2_q  <= '0;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      cnt_q <= cnt_d;
    end
  end

  assign in_ready  = en;
  assign out_valid = s2_q.valid;
  assign data_out  = s2_q.data;
  assign syndrome  = s2_q.syn;
  assign err_corr  = s2_q.err;
  assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_decoder_bo.sv
// Directed and exhaustive bench for decoder_bo: scoreboarded outputs, stall holding, counter model.
module tb_decoder_bo;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        clr_cnt;
  logic [14:0] data_in;

  logic        in_ready, out_valid, err_corr;
  logic [10:0] data_out;
  logic [3:0]  syndrome;
  logic [15:0] err_cnt16;

  logic        sat_in_ready, sat_out_valid, sat_err_corr;
  logic [10:0] sat_data_out;
  logic [3:0]  sat_syndrome;
  logic [1:0]  err_cnt2;

  always #5 clk = ~clk;

  decoder_bo #(.CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .syndrome(syndrome),
    .err_corr(err_corr), .clr_cnt(clr_cnt), .err_cnt(err_cnt16)
  );

  decoder_bo #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready), .data_in(data_in),
    .out_valid(sat_out_valid), .out_ready(out_ready), .data_out(sat_data_out),
    .syndrome(sat_syndrome), .err_corr(sat_err_corr), .clr_cnt(clr_cnt), .err_cnt(err_cnt2)
  );

  typedef struct {
    logic [14:0] cw;
    logic [10:0] data;
    logic [3:0]  syn;
    logic        err;
    int          cyc;
  } item_t;

  item_t src_q[$];
  item_t exp_q[$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit lat_chk, rand_stall, stall_on, clr_on_err;
  int stall_from, stall_to;
  int unsigned cnt16_m, cnt2_m;
  bit          prev_stall;
  logic [10:0] prev_data;
  logic [3:0]  prev_syn;
  logic        prev_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference syndrome: XOR of the positions of all set bits.
  function automatic logic [3:0] ref_syn(input logic [14:0] cw);
    logic [3:0] s = '0;
    for (int i = 0; i < 15; i++) if (cw[i]) s ^= 4'(i + 1);
    return s;
  endfunction

  function automatic logic [14:0] ref_enc(input logic [10:0] d);
    logic [14:0] cw = '0;
    logic [3:0]  s;
    int          k = 0;
    for (int i = 0; i < 15; i++) begin
      if (((i + 1) & i) != 0) begin
        cw[i] = d[k];
        k++;
      end
    end
    s = ref_syn(cw);
    cw[0] = s[0];
    cw[1] = s[1];
    cw[3] = s[2];
    cw[7] = s[3];
    return cw;
  endfunction

  task automatic push(input logic [14:0] cw, input logic [10:0] d, input logic [3:0] s, input logic e);
    item_t it;
    it.cw = cw; it.data = d; it.syn = s; it.err = e; it.cyc = 0;
    src_q.push_back(it);
  endtask

  // One clock cycle: drive, settle, score, then advance past the rising edge.
  task automatic step();
    item_t it;
    bit    inc = 1'b0;
    bit    in_fire, out_fire;
    in_valid  = (src_q.size() != 0);
    data_in   = in_valid ? src_q[0].cw : 15'h0;
    if (rand_stall) out_ready = ($urandom_range(0, 3) != 0);
    else            out_ready = !(stall_on && cyc >= stall_from && cyc < stall_to);
    #2;
    check("err_cnt16", 32'(err_cnt16), cnt16_m);
    check("err_cnt2", 32'(err_cnt2), cnt2_m);
    if (prev_stall) begin
      check("hold_valid", 32'(out_valid), 1);
      check("hold_data", 32'(data_out), 32'(prev_data));
      check("hold_syn", 32'(syndrome), 32'(prev_syn));
      check("hold_err", 32'(err_corr), 32'(prev_err));
    end
    if (out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 0);
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    if (out_fire) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(out_valid), 0);
      end else begin
        it = exp_q.pop_front();
        check("data_out", 32'(data_out), 32'(it.data));
        check("syndrome", 32'(syndrome), 32'(it.syn));
        check("err_corr", 32'(err_corr), 32'(it.err));
        if (lat_chk) check("latency", cyc - it.cyc, 2);
        inc = it.err;
      end
    end
    if (in_fire) begin
      it = src_q.pop_front();
      it.cyc = cyc;
      exp_q.push_back(it);
    end
    clr_cnt    = clr_on_err && inc;
    prev_stall = out_valid && !out_ready;
    prev_data  = data_out;
    prev_syn   = syndrome;
    prev_err   = err_corr;
    @(posedge clk);
    if (clr_cnt) begin
      cnt16_m = 0;
      cnt2_m  = 0;
    end else if (inc) begin
      if (cnt16_m < 65535) cnt16_m++;
      if (cnt2_m < 3) cnt2_m++;
    end
    @(negedge clk);
    clr_cnt = 1'b0;
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (src_q.size() != 0 || exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size() + src_q.size()), 0);
      src_q.delete();
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clr_cnt   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    src_q.delete();
    exp_q.delete();
    cnt16_m    = 0;
    cnt2_m     = 0;
    prev_stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0; data_in = '0;
    lat_chk = 1'b1; rand_stall = 1'b0; stall_on = 1'b0; clr_on_err = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_data_out", 32'(data_out), 0);
    check("rst_syndrome", 32'(syndrome), 0);
    check("rst_err_corr", 32'(err_corr), 0);
    check("rst_err_cnt16", 32'(err_cnt16), 0);
    check("rst_err_cnt2", 32'(err_cnt2), 0);
    @(negedge clk);

    // Directed words with hand-computed results, two-cycle latency checked
    push(15'h0000, 11'h000, 4'd0, 1'b0);
    push(15'h7FDF, 11'h7FF, 4'd6, 1'b1);
    push(15'h7F7F, 11'h7FF, 4'd8, 1'b1);
    push(15'h7FFF, 11'h7FF, 4'd0, 1'b0);
    drain(50);
    check("cnt16_after_directed", 32'(err_cnt16), 2);
    check("cnt2_after_directed", 32'(err_cnt2), 2);

    // Backpressure: four back-to-back words, output stalled for three cycles mid-stream
    lat_chk    = 1'b0;
    stall_on   = 1'b1;
    stall_from = cyc + 3;
    stall_to   = cyc + 6;
    push(15'h0000, 11'h000, 4'd0, 1'b0);
    push(15'h7FFF, 11'h7FF, 4'd0, 1'b0);
    push(15'h7FDF, 11'h7FF, 4'd6, 1'b1);
    push(15'h0001, 11'h000, 4'd1, 1'b1);
    drain(50);
    stall_on = 1'b0;
    check("cnt16_after_stall", 32'(err_cnt16), 4);
    check("cnt2_saturated", 32'(err_cnt2), 3);

    // More errors keep the narrow counter pinned at all-ones
    push(15'h4000, 11'h000, 4'd15, 1'b1);
    push(15'h7FFE, 11'h7FF, 4'd1, 1'b1);
    drain(50);
    check("cnt2_still_sat", 32'(err_cnt2), 3);
    check("cnt16_six", 32'(err_cnt16), 6);

    // Clear coincident with an increment: clear wins
    clr_on_err = 1'b1;
    push(15'h0002, 11'h000, 4'd2, 1'b1);
    drain(50);
    clr_on_err = 1'b0;
    check("clr_wins16", 32'(err_cnt16), 0);
    check("clr_wins2", 32'(err_cnt2), 0);

    // Reset with words in flight: discarded, ready right after reset
    push(15'h7FDF, 11'h7FF, 4'd6, 1'b1);
    push(15'h7F7F, 11'h7FF, 4'd8, 1'b1);
    step();
    step();
    do_reset();
    #1;
    check("flush_out_valid", 32'(out_valid), 0);
    check("flush_in_ready", 32'(in_ready), 1);
    check("flush_err_cnt", 32'(err_cnt16), 0);
    @(negedge clk);
    repeat (3) step();

    // Exhaustive: every data word, clean and with each single-bit flip, random output stalls
    rand_stall = 1'b1;
    for (int d = 0; d < 2048; d++) begin
      logic [14:0] cw;
      cw = ref_enc(11'(d));
      push(cw, 11'(d), 4'd0, 1'b0);
      for (int f = 0; f < 15; f++) push(cw ^ (15'h1 << f), 11'(d), 4'(f + 1), 1'b1);
    end
    drain(70000);
    rand_stall = 1'b0;
    check("cnt16_exhaustive", 32'(err_cnt16), 30720);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/decoder_bo.md
DECODER_BO -- requirements
Module: decoder_bo

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the error counter.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be the reset: synchronous, active-high.
REQ-004 Port in_valid, input, 1 bit, SHALL mark a valid codeword on data_in.
REQ-005 Port in_ready, output, 1 bit, SHALL mark that the block accepts a codeword this cycle.
REQ-006 Port data_in, input, 15 bits, SHALL carry the Hamming(15,11) codeword; bit i holds code position i+1.
REQ-007 Port out_valid, output, 1 bit, SHALL mark valid decoded data on data_out.
REQ-008 Port out_ready, input, 1 bit, SHALL mark that the consumer takes the output this cycle.
REQ-009 Port data_out, output, 11 bits, SHALL carry the corrected data word.
REQ-010 Port syndrome, output, 4 bits, SHALL carry the syndrome of the word on data_out.
REQ-011 Port err_corr, output, 1 bit, SHALL be high when syndrome is non-zero.
REQ-012 Port clr_cnt, input, 1 bit, SHALL synchronously clear err_cnt.
REQ-013 Port err_cnt, output, CNT_W bits, SHALL count delivered words with non-zero syndrome.

Function
REQ-014 The block SHALL compute the syndrome as follows.
- s[0] = XOR of cw[0,2,4,6,8,10,12,14]
- s[1] = XOR of cw[1,2,5,6,9,10,13,14]
- s[2] = XOR of cw[3,4,5,6,11,12,13,14]
- s[3] = XOR of cw[7..14]
REQ-015 Correction: if s != 0, bit cw[s-1] SHALL be inverted; if s = 0, no bit is changed.
REQ-016 Data extraction after correction: data_out[0]=cw[2], [1]=cw[4], [2]=cw[5], [3]=cw[6], [10:4]=cw[14:8].
REQ-017 The pipeline SHALL have two register stages.
- Stage 1: registered codeword, syndrome and valid flag.
- Stage 2: registered corrected data, syndrome, err_corr and out_valid.
REQ-018 Latency SHALL be exactly 2 cycles from input handshake to out_valid when out_ready stays high.
REQ-019 The advance enable SHALL be en = !out_valid | out_ready; in_ready SHALL equal en; both stages load only when en = 1.
REQ-020 A stage-1 bubble (stage-1 valid = 0) SHALL propagate as out_valid = 0; with en = 1 a new word is captured in the same cycle.
REQ-021 While out_valid = 1 and out_ready = 0, data_out, syndrome and err_corr SHALL stay stable and no input is accepted.
REQ-022 in_valid with in_ready = 0 SHALL have no effect; the source holds the word.
REQ-023 err_cnt SHALL increment by 1 on each cycle with out_valid & out_ready & err_corr, saturating at all-ones.
REQ-024 If clr_cnt and an increment occur in the same cycle, clear SHALL win: err_cnt = 0.
REQ-025 Double errors are not detected; they are miscorrected per REQ-015 with no additional flag.

Reset
REQ-026 On rst = 1 at a clock edge, both valid flags, data_out, syndrome, err_corr and err_cnt SHALL all be 0.
REQ-027 A word in flight when rst is asserted SHALL be discarded; in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-028 A shared package SHALL hold the constants DATA_W = 11 and CODE_W = 15 and the four parity-coverage masks; the matching encoder uses the same package.
REQ-029 The combinational syndrome-and-correct logic SHALL be one sub-module, hamming15_correct, instantiated between the stages.

Verification
REQ-030 Reset: after rst, in_valid = 1 with 0x0000, out_ready = 1 -> two cycles later out_valid = 1, data_out = 0x000, syndrome = 0, err_cnt = 0.
REQ-031 Data-bit error: 0x7FDF (0x7FFF with cw[5] flipped) -> data_out = 0x7FF, syndrome = 6, err_corr = 1, err_cnt = 1.
REQ-032 Parity-bit error: 0x7F7F (cw[7] flipped) -> data_out = 0x7FF, syndrome = 8, err_corr = 1.
REQ-033 Backpressure: 4 back-to-back words with out_ready low for 3 cycles mid-stream -> output held stable, in_ready = 0 while stalled, all 4 delivered in order, none lost or duplicated.
REQ-034 Counter saturation: CNT_W = 2 with 5 erroneous words -> err_cnt = 3; clr_cnt coincident with an increment -> err_cnt = 0.
REQ-035 Exhaustive: all 2048 words encoded, each with every single-bit flip and no flip -> data_out equals the original word in every case.
